// File: rtl/reglk_scrub_ctrl.sv
// reglk_scrub_ctrl
//   Register-lock controller in front of the 4-entry lockable register bank.
//   It holds the sticky per-register lock bits and drives the bank's lock
//   vector. It forwards host bus accesses to the bank's write port. Before a
//   lock is released, it zero-scrubs the protected register, so the next owner
//   never sees the old secret.
//
//   Optional build macro: REGLK_VIOL_CNT_EN adds viol_cnt_o. This is a
//   saturating count of accepted host writes that target a locked slot.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   host_en_i/we_i      host access request / write enable
//   host_addr_i/wdata_i host address / write data
//   host_ready_o        host access accepted when host_en_i && host_ready_o
//   lock_set_i          per-bit pulse: set sticky lock
//   unlock_req_i        per-bit pulse: request scrub-then-unlock
//   reglk_ctrl_o        registered lock vector to the bank
//   en_o/we_o           registered bank enable / write enable
//   address_o/wdata_o   registered bank address / write data
//   viol_cnt_o          (REGLK_VIOL_CNT_EN only) locked-write counter
//   busy_o              scrub sequence pending or in progress
module reglk_scrub_ctrl #(
  parameter int unsigned NREG       = 4,
  parameter logic [31:0] SCRUB_DATA = 32'h0000_0000,
  parameter logic [3:0]  LOCK_RST   = 4'h0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            host_en_i,
  input  logic            host_we_i,
  input  logic [31:0]     host_addr_i,
  input  logic [31:0]     host_wdata_i,
  output logic            host_ready_o,
  input  logic [NREG-1:0] lock_set_i,
  input  logic [NREG-1:0] unlock_req_i,
  output logic [NREG-1:0] reglk_ctrl_o,
  output logic            en_o,
  output logic            we_o,
  output logic [31:0]     address_o,
  output logic [31:0]     wdata_o,
`ifdef REGLK_VIOL_CNT_EN
  output logic [7:0]      viol_cnt_o,
`endif
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCRUB   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state;
  logic [NREG-1:0] lk;
  logic [NREG-1:0] pend;
  logic [1:0]      sel;

  logic [1:0]      pick;
  logic [NREG-1:0] pick_oh;
  logic [NREG-1:0] sel_oh;
  logic [NREG-1:0] lk_or;
  logic [NREG-1:0] pend_nx;
  logic [NREG-1:0] lk_rel;
  logic            host_acc;

  // Slot i is mapped to address_o[8:3] = NREG - i. All other bits are 0.
  function automatic logic [31:0] slot_addr(input logic [1:0] s);
    return 32'(NREG - 32'(s)) << 3;
  endfunction

  // The lowest pending slot is serviced first.
  always_comb begin
    pick = '0;
    for (int unsigned i = NREG; i > 0; i--) begin
      if (pend[i-1]) pick = 2'(i - 1);
    end
  end

  assign pick_oh  = NREG'(1) << pick;
  assign sel_oh   = NREG'(1) << sel;
  assign lk_or    = lk | lock_set_i;
  // If a lock is set in the same cycle as its unlock request, the set wins.
  // Requests for unlocked bits are dropped.
  assign pend_nx  = pend | (unlock_req_i & lk & ~lock_set_i);
  // A lock set during the scrub cycle keeps the slot locked. The slot is
  // already scrubbed, which is harmless.
  assign lk_rel   = lk_or & ~(sel_oh & ~lock_set_i);

  assign host_ready_o = rst_ni && (state == IDLE) && (pend == '0);
  assign busy_o       = (pend != '0) || (state != IDLE);
  assign host_acc     = host_en_i && host_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      lk           <= LOCK_RST;
      pend         <= '0;
      sel          <= '0;
      reglk_ctrl_o <= LOCK_RST;
      en_o         <= 1'b0;
      we_o         <= 1'b0;
      address_o    <= '0;
      wdata_o      <= '0;
    end else begin
      lk   <= lk_or;
      pend <= pend_nx;
      unique case (state)
        SCRUB: begin
          // The bank samples the scrub write in this cycle. Drop the lock now.
          state        <= RELEASE;
          lk           <= lk_rel;
          pend         <= pend_nx & ~sel_oh;
          reglk_ctrl_o <= lk_rel;
          en_o         <= 1'b0;
          we_o         <= 1'b0;
        end
        default: begin
          // IDLE and RELEASE share the scrub load. host_acc can only be true
          // in IDLE with nothing pending.
          if (pend != '0) begin
            state        <= SCRUB;
            sel          <= pick;
            en_o         <= 1'b1;
            we_o         <= 1'b1;
            address_o    <= slot_addr(pick);
            wdata_o      <= SCRUB_DATA;
            reglk_ctrl_o <= lk_or & ~pick_oh;
          end else begin
            state        <= IDLE;
            reglk_ctrl_o <= lk_or;
            en_o         <= host_acc;
            we_o         <= host_acc && host_we_i;
            if (host_acc) begin
              address_o <= host_addr_i;
              wdata_o   <= host_wdata_i;
            end
          end
        end
      endcase
    end
  end

`ifdef REGLK_VIOL_CNT_EN
  logic viol_hit;

  always_comb begin
    viol_hit = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (lk[i] && (host_addr_i == slot_addr(2'(i)))) viol_hit = 1'b1;
    end
  end

  // Only host writes are counted. A scrub never passes through host_acc.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      viol_cnt_o <= '0;
    end else if (host_acc && host_we_i && viol_hit && (viol_cnt_o != 8'hFF)) begin
      viol_cnt_o <= viol_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reglk_scrub_ctrl.sv
module tb_reglk_scrub_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        host_en_i = 1'b0;
  logic        host_we_i = 1'b0;
  logic [31:0] host_addr_i = '0;
  logic [31:0] host_wdata_i = '0;
  logic        host_ready_o;
  logic [3:0]  lock_set_i = '0;
  logic [3:0]  unlock_req_i = '0;
  logic [3:0]  reglk_ctrl_o;
  logic        en_o;
  logic        we_o;
  logic [31:0] address_o;
  logic [31:0] wdata_o;
  logic        busy_o;
`ifdef REGLK_VIOL_CNT_EN
  logic [7:0]  viol_cnt_o;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  reglk_scrub_ctrl #(
    .NREG      (4),
    .SCRUB_DATA(32'h0000_0000),
    .LOCK_RST  (4'h0)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .host_en_i   (host_en_i),
    .host_we_i   (host_we_i),
    .host_addr_i (host_addr_i),
    .host_wdata_i(host_wdata_i),
    .host_ready_o(host_ready_o),
    .lock_set_i  (lock_set_i),
    .unlock_req_i(unlock_req_i),
    .reglk_ctrl_o(reglk_ctrl_o),
    .en_o        (en_o),
    .we_o        (we_o),
    .address_o   (address_o),
    .wdata_o     (wdata_o),
`ifdef REGLK_VIOL_CNT_EN
    .viol_cnt_o  (viol_cnt_o),
`endif
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock. Outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    check_eq("rst_en", 32'(en_o), 0);
    check_eq("rst_reglk", 32'(reglk_ctrl_o), 32'h0);
    check_eq("rst_ready_low", 32'(host_ready_o), 0);
    step();
    rst_ni = 1'b1;
    step();
    check_eq("post_rst_ready", 32'(host_ready_o), 1);
    check_eq("post_rst_busy", 32'(busy_o), 0);
    check_eq("post_rst_addr", address_o, 32'h0);
    check_eq("post_rst_wdata", wdata_o, 32'h0);

    // Host write passthrough
    host_en_i = 1'b1; host_we_i = 1'b1; host_addr_i = 32'h20; host_wdata_i = 32'hDEADBEEF;
    step();
    host_en_i = 1'b0; host_we_i = 1'b0;
    check_eq("hw_en", 32'(en_o), 1);
    check_eq("hw_we", 32'(we_o), 1);
    check_eq("hw_addr", address_o, 32'h20);
    check_eq("hw_wdata", wdata_o, 32'hDEADBEEF);
    step();
    check_eq("hw_en_drop", 32'(en_o), 0);
    check_eq("hw_we_drop", 32'(we_o), 0);

    // Single lock and unlock of slot 0
    lock_set_i = 4'b0001;
    step();
    lock_set_i = 4'b0000;
    check_eq("lk0_reglk", 32'(reglk_ctrl_o), 32'h1);
    unlock_req_i = 4'b0001;
    step();
    unlock_req_i = 4'b0000;
    check_eq("ul0_busy", 32'(busy_o), 1);
    check_eq("ul0_ready", 32'(host_ready_o), 0);
    step();
    check_eq("sc0_en", 32'(en_o), 1);
    check_eq("sc0_we", 32'(we_o), 1);
    check_eq("sc0_addr", address_o, 32'h20);
    check_eq("sc0_wdata", wdata_o, 32'h0);
    check_eq("sc0_reglk", 32'(reglk_ctrl_o), 32'h0);
    step();
    check_eq("rl0_en", 32'(en_o), 0);
    check_eq("rl0_reglk", 32'(reglk_ctrl_o), 32'h0);
    check_eq("rl0_busy", 32'(busy_o), 1);
    step();
    check_eq("id0_busy", 32'(busy_o), 0);
    check_eq("id0_ready", 32'(host_ready_o), 1);

    // Lock all slots, then unlock slots 1 and 3. Slot 1 is serviced first.
    lock_set_i = 4'hF;
    step();
    lock_set_i = 4'h0;
    check_eq("lkF_reglk", 32'(reglk_ctrl_o), 32'hF);
    unlock_req_i = 4'b1010;
    step();
    unlock_req_i = 4'b0000;
    step();
    check_eq("sc1_en", 32'(en_o), 1);
    check_eq("sc1_addr", address_o, 32'h18);
    check_eq("sc1_reglk", 32'(reglk_ctrl_o), 32'hD);
    step();
    check_eq("rl1_en", 32'(en_o), 0);
    step();
    check_eq("sc3_en", 32'(en_o), 1);
    check_eq("sc3_addr", address_o, 32'h08);
    check_eq("sc3_reglk", 32'(reglk_ctrl_o), 32'h5);
    step();
    check_eq("rl3_en", 32'(en_o), 0);
    step();
    check_eq("multi_busy", 32'(busy_o), 0);
    check_eq("multi_reglk", 32'(reglk_ctrl_o), 32'h5);

    // Set and unlock of slot 2 in the same cycle: set wins
    lock_set_i = 4'b0100; unlock_req_i = 4'b0100;
    step();
    lock_set_i = 4'b0000; unlock_req_i = 4'b0000;
    check_eq("sw_busy", 32'(busy_o), 0);
    check_eq("sw_reglk2", 32'(reglk_ctrl_o[2]), 1);
    step();
    check_eq("sw_en", 32'(en_o), 0);

    // Host access in the same cycle as an unlock request. The host access
    // completes first, and the scrub follows on the next edge.
    host_en_i = 1'b1; host_we_i = 1'b1; host_addr_i = 32'h10; host_wdata_i = 32'h1234;
    unlock_req_i = 4'b0001;
    step();
    host_en_i = 1'b0; host_we_i = 1'b0; unlock_req_i = 4'b0000;
    check_eq("hu_en", 32'(en_o), 1);
    check_eq("hu_addr", address_o, 32'h10);
    check_eq("hu_wdata", wdata_o, 32'h1234);
    check_eq("hu_busy", 32'(busy_o), 1);
    step();
    check_eq("hu_sc_addr", address_o, 32'h20);
    check_eq("hu_sc_wdata", wdata_o, 32'h0);
    check_eq("hu_sc_reglk", 32'(reglk_ctrl_o), 32'h4);
    step();
    step();
    check_eq("hu_done", 32'(busy_o), 0);

    // Reset asserted during the SCRUB cycle
    lock_set_i = 4'b0010;
    step();
    lock_set_i = 4'b0000;
    unlock_req_i = 4'b0010;
    step();
    unlock_req_i = 4'b0000;
    step();
    check_eq("mr_sc_en", 32'(en_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("mr_en", 32'(en_o), 0);
    check_eq("mr_reglk", 32'(reglk_ctrl_o), 32'h0);
    check_eq("mr_ready", 32'(host_ready_o), 0);
    #2 rst_ni = 1'b1;
    step();
    check_eq("mr_post_ready", 32'(host_ready_o), 1);
    check_eq("mr_post_busy", 32'(busy_o), 0);
    check_eq("mr_post_reglk", 32'(reglk_ctrl_o), 32'h0);

`ifdef REGLK_VIOL_CNT_EN
    check_eq("vc_rst", 32'(viol_cnt_o), 0);
    lock_set_i = 4'b0001;
    step();
    lock_set_i = 4'b0000;
    host_en_i = 1'b1; host_we_i = 1'b1; host_addr_i = 32'h10;
    for (int i = 0; i < 5; i++) step();
    check_eq("vc_unlocked", 32'(viol_cnt_o), 0);
    host_addr_i = 32'h20;
    for (int i = 0; i < 3; i++) step();
    check_eq("vc_three", 32'(viol_cnt_o), 3);
    host_addr_i = 32'h10;
    for (int i = 0; i < 4; i++) step();
    check_eq("vc_hold", 32'(viol_cnt_o), 3);
    host_addr_i = 32'h20;
    for (int i = 0; i < 300; i++) step();
    check_eq("vc_sat", 32'(viol_cnt_o), 32'hFF);
    host_addr_i = 32'h10;
    for (int i = 0; i < 3; i++) step();
    host_en_i = 1'b0; host_we_i = 1'b0;
    check_eq("vc_sat_hold", 32'(viol_cnt_o), 32'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
